sram_line_ctrl: RTL



---
 rtl/gpu_sram_pkg.sv | 27 ++
 rtl/sram_line_ctrl_if.sv | 23 ++
 rtl/sram_beat_counter.sv | 37 +++
 rtl/sram_line_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gpu_sram_pkg.sv
// Shared constants, FSM state type and slice helper for the SRAM line controller.
package gpu_sram_pkg;

  localparam int LINE_W      = 1536;
  localparam int WORD_W      = 32;
  localparam int BEATS       = 48;
  localparam int LINE_ADDR_W = 19;
  localparam int SRAM_ADDR_W = 25;
  localparam int BEAT_W      = 6;
  localparam int OFF_W       = 11;  // bit offset of a word inside a line

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } line_state_t;

  // Bit offset of beat k inside a line (k * 32).
  function automatic logic [OFF_W-1:0] beat_offset(input logic [BEAT_W-1:0] k);
    return {k, 5'd0};
  endfunction

endpackage

// File: rtl/sram_line_ctrl_if.sv
// Line request bus between the request multiplexer (master) and the controller (slave).
interface sram_line_ctrl_if;
  import gpu_sram_pkg::*;

  logic                   read_enable;
  logic                   write_enable;
  logic [LINE_ADDR_W-1:0] address;
  logic [LINE_W-1:0]      write_data;
  logic [LINE_W-1:0]      read_data;
  logic                   busy;
  logic                   done;

  modport master (
    output read_enable, write_enable, address, write_data,
    input  read_data, busy, done
  );

  modport slave (
    input  read_enable, write_enable, address, write_data,
    output read_data, busy, done
  );

endinterface

// File: rtl/sram_beat_counter.sv
// Six-bit beat counter that saturates at the last beat of a line.
module sram_beat_counter
  import gpu_sram_pkg::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clr_i,
  input  logic              en_i,
  output logic [BEAT_W-1:0] count_o,
  output logic              term_o
);

  logic [BEAT_W-1:0] count_q, count_d;

  // Clear has priority; counting stops at the last beat so 48..63 never occur.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i && (count_q != LAST_BEAT)) begin
      count_d = count_q + BEAT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign term_o  = (count_q == LAST_BEAT);

endmodule

// File: rtl/sram_line_ctrl.sv
// Executes one 1536-bit line request as 48 sequential 32-bit SRAM beats and
// reassembles read lines from the delayed SRAM return data.
module sram_line_ctrl
  import gpu_sram_pkg::*;
#(
  parameter int READ_LAT = 1
) (
  input  logic                   clk,
  input  logic                   n_rst,
  sram_line_ctrl_if.slave        bus,
  output logic [SRAM_ADDR_W-1:0] sram_addr,
  output logic [WORD_W-1:0]      sram_wdata,
  output logic                   sram_we,
  output logic                   sram_re,
  input  logic [WORD_W-1:0]      sram_rdata
);

  line_state_t state_q, state_d;

  logic [LINE_ADDR_W-1:0] line_q;
  logic [LINE_W-1:0]      wline_q;
  logic [LINE_W-1:0]      cap_q, cap_d;
  logic [LINE_W-1:0]      rdata_q;

  logic                   busy_q, busy_d, done_q, done_d;
  logic                   we_q, we_d, re_q, re_d;
  logic [SRAM_ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]      wdata_q, wdata_d;

  logic                   accept, issuing;
  logic [BEAT_W-1:0]      issue_cnt, issue_nxt, cap_cnt;
  logic                   issue_term, cap_term;

  logic [READ_LAT-1:0]             ret_vld_q;
  logic [READ_LAT-1:0][BEAT_W-1:0] ret_idx_q;
  logic                            ret_vld;
  logic [BEAT_W-1:0]               ret_idx;
  logic                            unused_cap;

  assign accept     = (state_q == ST_IDLE) && (bus.write_enable || bus.read_enable);
  assign issuing    = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign issue_nxt  = issue_cnt + BEAT_W'(1);
  assign ret_vld    = ret_vld_q[READ_LAT-1];
  assign ret_idx    = ret_idx_q[READ_LAT-1];
  assign unused_cap = ^cap_cnt;

  // Beat currently on the SRAM bus.
  sram_beat_counter u_issue_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr_i   (accept),
    .en_i    (issuing && !issue_term),
    .count_o (issue_cnt),
    .term_o  (issue_term)
  );

  // Number of read returns captured so far; terminal means beat 47 is next.
  sram_beat_counter u_cap_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr_i   (accept),
    .en_i    (ret_vld && !cap_term),
    .count_o (cap_cnt),
    .term_o  (cap_term)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; write wins over read, requests ignored outside IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.write_enable)     state_d = ST_WRITE;
        else if (bus.read_enable) state_d = ST_READ;
      end
      ST_WRITE: if (issue_term)          state_d = ST_DONE;
      ST_READ:  if (issue_term)          state_d = ST_DRAIN;
      ST_DRAIN: if (ret_vld && cap_term) state_d = ST_DONE;
      ST_DONE:                           state_d = ST_IDLE;
      default:                           state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: next values for the registered SRAM strobes, address and data.
  always_comb begin
    we_d    = 1'b0;
    re_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    if (accept) begin
      addr_d = {bus.address, BEAT_W'(0)};
      if (bus.write_enable) begin
        we_d    = 1'b1;
        wdata_d = bus.write_data[WORD_W-1:0];
      end else begin
        re_d = 1'b1;
      end
    end else if (issuing && !issue_term) begin
      addr_d = {line_q, issue_nxt};
      if (state_q == ST_WRITE) begin
        we_d    = 1'b1;
        wdata_d = wline_q[beat_offset(issue_nxt) +: WORD_W];
      end else begin
        re_d = 1'b1;
      end
    end
  end

  // Registered outputs toward the SRAM and the requester.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      we_q    <= we_d;
      re_q    <= re_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Merge the returning word into the capture line.
  always_comb begin
    cap_d = cap_q;
    if (ret_vld) begin
      cap_d[beat_offset(ret_idx) +: WORD_W] = sram_rdata;
    end
  end

  // Request latch, capture line, and whole-line publish when the last return lands.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      line_q  <= '0;
      wline_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        line_q  <= bus.address;
        wline_q <= bus.write_data;
      end
      cap_q <= cap_d;
      if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
        rdata_q <= cap_d;
      end
    end
  end

  // First return-pipeline stage: records the beat that was just issued.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ret_vld_q[0] <= 1'b0;
      ret_idx_q[0] <= '0;
    end else begin
      ret_vld_q[0] <= re_q;
      ret_idx_q[0] <= addr_q[BEAT_W-1:0];
    end
  end

  generate
    for (genvar gi = 1; gi < READ_LAT; gi++) begin : g_ret_pipe
      // Remaining stages delay the valid/index pair to match SRAM latency.
      always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
          ret_vld_q[gi] <= 1'b0;
          ret_idx_q[gi] <= '0;
        end else begin
          ret_vld_q[gi] <= ret_vld_q[gi-1];
          ret_idx_q[gi] <= ret_idx_q[gi-1];
        end
      end
    end
  endgenerate

  assign sram_addr     = addr_q;
  assign sram_wdata    = wdata_q;
  assign sram_we       = we_q;
  assign sram_re       = re_q;
  assign bus.read_data = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
